// File: rtl/pht_arbiter.sv
// Pattern history table of 2-bit counters shared by fetch lookups and
// buffered execute-stage updates through one table port.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   lookup_valid/_index   fetch lookup request
//   lookup_ready          lookup accepted when high with lookup_valid
//   pred_valid/_taken     prediction, one cycle after acceptance
//   pred_index            echo of accepted lookup index
//   upd_valid/_index      resolved branch to record
//   upd_taken             actual outcome
//   upd_ready             update accepted into the FIFO
//   busy                  update FIFO non-empty
module pht_arbiter #(
  parameter int INDEX_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_STALL  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_index,
  output logic               lookup_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken,
  output logic               upd_ready,
  output logic               busy
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STALL_C = SW'(MAX_STALL);

  logic [1:0]         pht [ENTRIES];
  logic [INDEX_W-1:0] q_idx [FIFO_DEPTH];
  logic               q_tkn [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] stall_cnt;

  logic not_empty;
  logic full;
  logic force_drain;
  logic gnt_lookup;
  logic gnt_drain;
  logic push;

  logic [INDEX_W-1:0] head_idx;
  logic               head_tkn;
  logic [1:0]         head_ctr;
  logic [1:0]         new_ctr;

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_C);

  // Starvation guard: a full FIFO or a long run of lookups
  // forces the port over to draining.
  assign force_drain = full ||
    (not_empty && stall_cnt == STALL_C);

  always_comb begin
    gnt_lookup = 1'b0;
    gnt_drain  = 1'b0;
    priority case (1'b1)
      force_drain:  gnt_drain  = 1'b1;
      lookup_valid: gnt_lookup = 1'b1;
      not_empty:    gnt_drain  = 1'b1;
      default: ;
    endcase
  end

  assign lookup_ready = !force_drain;
  assign upd_ready    = (count < DEPTH_C);
  assign busy         = not_empty;
  assign push         = upd_valid && upd_ready;

  assign head_idx = q_idx[rd_ptr];
  assign head_tkn = q_tkn[rd_ptr];
  assign head_ctr = pht[head_idx];

  always_comb begin
    new_ctr = head_ctr;
    if (head_tkn) begin
      if (head_ctr != 2'b11) new_ctr = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'b00) new_ctr = head_ctr - 2'd1;
    end
  end

  // FIFO payload needs no reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr] <= upd_index;
      q_tkn[wr_ptr] <= upd_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (gnt_drain) rd_ptr <= rd_ptr + 1'b1;
      case ({push, gnt_drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (gnt_drain || !not_empty) begin
      stall_cnt <= '0;
    end else if (gnt_lookup && stall_cnt != STALL_C) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= 2'b11;
    end else if (gnt_drain) begin
      pht[head_idx] <= new_ctr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_index <= '0;
    end else if (gnt_lookup) begin
      pred_valid <= 1'b1;
      pred_taken <= pht[lookup_index][1];
      pred_index <= lookup_index;
    end else begin
      pred_valid <= 1'b0;
    end
  end

endmodule
